axi_mmio_console: RTL and testbench

//  AXI4 responder (slave) for the rocketchip_wrapper M_AXI_MMIO port, so that MMIO stops being tied off in simulation.

---
 rtl/axi_mmio_pkg.sv | 35 +++
 rtl/axi_mmio_burst_addr.sv | 61 ++++++
 rtl/axi_mmio_console.sv | 246 ++++++++++++++++++++++++
 tb/tb_axi_mmio_console.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mmio_pkg.sv
// Shared encodings for the MMIO console: AXI response/burst codes, register
// indices, FSM states and the per-beat decode record.
package axi_mmio_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // Register index = window offset [4:3]
  localparam logic [1:0] REG_TX      = 2'd0;
  localparam logic [1:0] REG_RX      = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_SCRATCH = 2'd3;

  localparam int WIN_BYTES = 32;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_e;

  typedef struct packed {
    logic [1:0] resp;
    logic [1:0] idx;
    logic       last;
  } beat_info_t;

  // Encodings are ordered so that DECERR > SLVERR > OKAY numerically.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_mmio_burst_addr.sv
// Burst address/beat tracker shared by the write and read paths. Decodes either
// the current beat or (LOOKAHEAD) the beat that will be current next cycle.
module axi_mmio_burst_addr
  import axi_mmio_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h6000_0000,
  parameter bit                    LOOKAHEAD  = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  i_load,
  input  logic                  i_adv,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [7:0]            i_len,
  input  logic [1:0]            i_burst,
  output beat_info_t            o_beat
);

  logic [ADDR_WIDTH-1:0] r_addr, w_nxt_addr, w_step_addr, w_addr, w_off;
  logic [7:0]            r_cnt, r_len, w_nxt_cnt, w_nxt_len, w_cnt, w_len;
  logic [1:0]            r_burst, w_nxt_burst, w_burst;

  always_comb begin
    w_step_addr = (r_burst == BURST_INCR) ? r_addr + ADDR_WIDTH'(8) : r_addr;
    w_nxt_addr  = i_load ? i_addr  : (i_adv ? w_step_addr : r_addr);
    w_nxt_cnt   = i_load ? 8'd0    : (i_adv ? r_cnt + 8'd1 : r_cnt);
    w_nxt_len   = i_load ? i_len   : r_len;
    w_nxt_burst = i_load ? i_burst : r_burst;

    w_addr  = LOOKAHEAD ? w_nxt_addr  : r_addr;
    w_cnt   = LOOKAHEAD ? w_nxt_cnt   : r_cnt;
    w_len   = LOOKAHEAD ? w_nxt_len   : r_len;
    w_burst = LOOKAHEAD ? w_nxt_burst : r_burst;

    w_off       = w_addr - BASE_ADDR;
    o_beat.idx  = w_off[4:3];
    o_beat.last = (w_cnt == w_len);
    if (w_addr < BASE_ADDR || w_off >= ADDR_WIDTH'(WIN_BYTES))
      o_beat.resp = RESP_DECERR;
    else if (w_burst == BURST_WRAP)
      o_beat.resp = RESP_SLVERR;
    else
      o_beat.resp = RESP_OKAY;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_addr  <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_burst <= BURST_FIXED;
    end else begin
      r_addr  <= w_nxt_addr;
      r_cnt   <= w_nxt_cnt;
      r_len   <= w_nxt_len;
      r_burst <= w_nxt_burst;
    end
  end

endmodule

// File: rtl/axi_mmio_console.sv
// AXI4 MMIO responder: TX/RX byte streams, status and scratch registers.
// Write (AW/W/B) and read (AR/R) paths run independently.
module axi_mmio_console
  import axi_mmio_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ID_WIDTH   = 5,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h6000_0000
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready
);

  wr_state_e             r_wstate;
  rd_state_e             r_rstate;
  logic                  r_awready, r_bvalid, r_arready, r_rvalid, r_rlast, r_rpop;
  logic [1:0]            r_bresp, r_werr, r_rresp, r_rerr;
  logic [ID_WIDTH-1:0]   r_bid, r_rid;
  logic [DATA_WIDTH-1:0] r_rdata, r_scratch;
  logic [7:0]            r_tx_data, r_rx_byte;
  logic                  r_tx_valid, r_rx_full;

  beat_info_t            w_wbeat, w_rbeat;
  logic                  w_aw_hs, w_w_hs, w_ar_hs, w_r_hs, w_wready, w_tx_stall;
  logic                  w_wmis, w_wr_en, w_tx_load, w_rx_pop, w_rx_full_eff, w_rd_load;
  logic [1:0]            w_wresp, w_rresp_n;
  logic [DATA_WIDTH-1:0] w_rdata_n;

  axi_mmio_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH), .BASE_ADDR(BASE_ADDR), .LOOKAHEAD(1'b0)) u_wr_addr (
    .clock   (clock),
    .reset_n (reset_n),
    .i_load  (w_aw_hs),
    .i_adv   (w_w_hs),
    .i_addr  (s_axi_awaddr),
    .i_len   (s_axi_awlen),
    .i_burst (s_axi_awburst),
    .o_beat  (w_wbeat)
  );

  // Read side decodes the beat being loaded so rdata can be registered with it.
  axi_mmio_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH), .BASE_ADDR(BASE_ADDR), .LOOKAHEAD(1'b1)) u_rd_addr (
    .clock   (clock),
    .reset_n (reset_n),
    .i_load  (w_ar_hs),
    .i_adv   (w_r_hs && !r_rlast),
    .i_addr  (s_axi_araddr),
    .i_len   (s_axi_arlen),
    .i_burst (s_axi_arburst),
    .o_beat  (w_rbeat)
  );

  always_comb begin
    w_aw_hs    = s_axi_awvalid && r_awready;
    w_ar_hs    = s_axi_arvalid && r_arready;
    w_r_hs     = r_rvalid && s_axi_rready;
    // A TX beat may only land once the pending byte is leaving this cycle.
    w_tx_stall = (w_wbeat.resp == RESP_OKAY) && (w_wbeat.idx == REG_TX) && s_axi_wstrb[0] &&
                 r_tx_valid && !tx_ready;
    w_wready   = (r_wstate == W_DATA) && !w_tx_stall;
    w_w_hs     = s_axi_wvalid && w_wready;
    w_wmis     = (s_axi_wlast != w_wbeat.last);
    w_wresp    = resp_max(r_werr, resp_max(w_wbeat.resp, w_wmis ? RESP_SLVERR : RESP_OKAY));
    w_wr_en    = w_w_hs && (w_wbeat.resp == RESP_OKAY);
    w_tx_load  = w_wr_en && (w_wbeat.idx == REG_TX) && s_axi_wstrb[0];

    w_rx_pop      = w_r_hs && r_rpop;
    w_rx_full_eff = r_rx_full && !w_rx_pop;
    rx_ready      = !r_rx_full || w_rx_pop;

    w_rd_load = w_ar_hs || (w_r_hs && !r_rlast);
    w_rresp_n = resp_max((r_rstate == R_IDLE) ? RESP_OKAY : r_rerr, w_rbeat.resp);
    w_rdata_n = '0;
    if (w_rbeat.resp == RESP_OKAY) begin
      case (w_rbeat.idx)
        REG_RX:      w_rdata_n = DATA_WIDTH'({w_rx_full_eff, r_rx_byte});
        REG_STATUS:  w_rdata_n = DATA_WIDTH'({w_rx_full_eff, r_tx_valid});
        REG_SCRATCH: w_rdata_n = r_scratch;
        default:     w_rdata_n = '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_bid     <= '0;
      r_werr    <= RESP_OKAY;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_awready <= 1'b0;
            r_bid     <= s_axi_awid;
            r_werr    <= RESP_OKAY;
            r_wstate  <= W_DATA;
          end else begin
            r_awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_w_hs) begin
            r_werr <= w_wresp;
            if (s_axi_wlast) begin
              r_bresp  <= w_wresp;
              r_bvalid <= 1'b1;
              r_wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
      r_rerr    <= RESP_OKAY;
      r_rid     <= '0;
      r_rpop    <= 1'b0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_arready <= 1'b0;
            r_rid     <= s_axi_arid;
            r_rvalid  <= 1'b1;
            r_rstate  <= R_DATA;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (w_r_hs && r_rlast) begin
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rpop    <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
      if (w_rd_load) begin
        r_rdata <= w_rdata_n;
        r_rresp <= w_rresp_n;
        r_rerr  <= w_rresp_n;
        r_rlast <= w_rbeat.last;
        r_rpop  <= (w_rbeat.resp == RESP_OKAY) && (w_rbeat.idx == REG_RX) && w_rx_full_eff;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_rx_byte  <= '0;
      r_rx_full  <= 1'b0;
      r_scratch  <= '0;
    end else begin
      if (w_tx_load) begin
        r_tx_data  <= s_axi_wdata[7:0];
        r_tx_valid <= 1'b1;
      end else if (r_tx_valid && tx_ready) begin
        r_tx_valid <= 1'b0;
      end
      if (rx_valid && rx_ready) begin
        r_rx_byte <= rx_data;
        r_rx_full <= 1'b1;
      end else if (w_rx_pop) begin
        r_rx_full <= 1'b0;
      end
      if (w_wr_en && (w_wbeat.idx == REG_SCRATCH)) begin
        for (int b = 0; b < DATA_WIDTH/8; b++)
          if (s_axi_wstrb[b]) r_scratch[8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = w_wready;
  assign s_axi_bid     = r_bid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_arready = r_arready;
  assign s_axi_rid     = r_rid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rlast   = r_rlast;
  assign s_axi_rvalid  = r_rvalid;
  assign tx_data       = r_tx_data;
  assign tx_valid      = r_tx_valid;

endmodule

// File: tb/tb_axi_mmio_console.sv
// Directed bench for axi_mmio_console: console TX/RX, scratch, errors, concurrency.
module tb_axi_mmio_console;

  localparam logic [63:0] BASE = 64'h6000_0000;
  localparam int          TMO  = 50;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  awid = '0, arid = '0, bid, rid;
  logic [63:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
  logic [7:0]  awlen = '0, arlen = '0, wstrb = '0, tx_data, rx_data = '0;
  logic [2:0]  awsize = 3'd3, arsize = 3'd3;
  logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
  logic        awvalid = 0, awready, wlast = 0, wvalid = 0, wready, bvalid, bready = 0;
  logic        arvalid = 0, arready, rlast, rvalid, rready = 0;
  logic        tx_valid, tx_ready = 0, rx_valid = 0, rx_ready;

  int cmps = 0;
  int errs = 0;

  always #5 clock = ~clock;

  axi_mmio_console dut (
    .clock(clock), .reset_n(reset_n),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  // All tasks start and return at posedge+1.
  task automatic do_aw(input logic [4:0] id, input logic [63:0] a, input logic [7:0] len,
                       input logic [1:0] burst);
    int n = 0;
    awid = id; awaddr = a; awlen = len; awburst = burst; awvalid = 1;
    #1;
    while (!awready && n < TMO) begin @(posedge clock); #1; n++; end
    if (!awready) begin cmps++; errs++; $display("FAIL aw_timeout got awready=0 want 1"); end
    @(posedge clock); #1;
    awvalid = 0;
  endtask

  task automatic do_w(input logic [63:0] d, input logic [7:0] s, input logic l);
    int n = 0;
    wdata = d; wstrb = s; wlast = l; wvalid = 1;
    #1;
    while (!wready && n < TMO) begin @(posedge clock); #1; n++; end
    if (!wready) begin cmps++; errs++; $display("FAIL w_timeout got wready=0 want 1"); end
    @(posedge clock); #1;
    wvalid = 0;
  endtask

  task automatic do_b(output logic [4:0] id, output logic [1:0] resp);
    int n = 0;
    bready = 1;
    #1;
    while (!bvalid && n < TMO) begin @(posedge clock); #1; n++; end
    if (!bvalid) begin cmps++; errs++; $display("FAIL b_timeout got bvalid=0 want 1"); end
    id = bid; resp = bresp;
    @(posedge clock); #1;
    bready = 0;
  endtask

  task automatic do_ar(input logic [4:0] id, input logic [63:0] a, input logic [7:0] len,
                       input logic [1:0] burst);
    int n = 0;
    arid = id; araddr = a; arlen = len; arburst = burst; arvalid = 1;
    #1;
    while (!arready && n < TMO) begin @(posedge clock); #1; n++; end
    if (!arready) begin cmps++; errs++; $display("FAIL ar_timeout got arready=0 want 1"); end
    @(posedge clock); #1;
    arvalid = 0;
  endtask

  task automatic do_r(output logic [4:0] id, output logic [63:0] d, output logic [1:0] resp,
                      output logic l);
    int n = 0;
    rready = 1;
    #1;
    while (!rvalid && n < TMO) begin @(posedge clock); #1; n++; end
    if (!rvalid) begin cmps++; errs++; $display("FAIL r_timeout got rvalid=0 want 1"); end
    id = rid; d = rdata; resp = rresp; l = rlast;
    @(posedge clock); #1;
    rready = 0;
  endtask

  task automatic test_reset();
    logic [15:0] got;
    #2;
    got = {awready, wready, bvalid, arready, rvalid, rlast, tx_valid, bresp, rresp, tx_data[3:0], 1'b0};
    cmps++;
    if (got !== 16'h0 || rdata !== 64'h0) begin
      errs++; $display("FAIL reset_outputs got %h rdata=%h want 0", got, rdata);
    end
    cmps++;
    if (rx_ready !== 1'b1) begin errs++; $display("FAIL reset_rx_ready got %b want 1", rx_ready); end
    @(posedge clock); #1; reset_n = 1;
    @(posedge clock); #1;
    cmps++;
    if (awready !== 1'b1 || arready !== 1'b1) begin
      errs++; $display("FAIL idle_ready got aw=%b ar=%b want 1 1", awready, arready);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [4:0] id; logic [1:0] resp;
    do_aw(5'd3, BASE + 64'h18, 8'd3, 2'b01);
    do_w(64'hDEAD_BEEF, 8'hFF, 1'b0);
    reset_n = 0;
    #1;
    cmps++;
    if ({awready, wready, bvalid, arready, rvalid, rlast, tx_valid} !== 7'b0 ||
        bresp !== 2'b00 || rresp !== 2'b00 || rdata !== 64'h0) begin
      errs++;
      $display("FAIL midburst_reset got aw=%b w=%b b=%b ar=%b r=%b rl=%b tx=%b want all 0",
               awready, wready, bvalid, arready, rvalid, rlast, tx_valid);
    end
    @(posedge clock); #1; reset_n = 1;
    @(posedge clock); #1;
    do_aw(5'd5, BASE + 64'h10, 8'd0, 2'b01);
    do_w(64'h0, 8'hFF, 1'b1);
    do_b(id, resp);
    cmps++;
    if (id !== 5'd5 || resp !== 2'b00) begin
      errs++; $display("FAIL post_reset_write got id=%0d resp=%b want 5 00", id, resp);
    end
  endtask

  task automatic test_tx_single();
    logic [4:0] id; logic [1:0] resp;
    tx_ready = 1;
    do_aw(5'd7, BASE, 8'd0, 2'b01);
    do_w(64'h41, 8'h01, 1'b1);
    cmps++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h41 || bvalid !== 1'b1) begin
      errs++; $display("FAIL tx_single got v=%b d=%h bvalid=%b want 1 41 1", tx_valid, tx_data, bvalid);
    end
    @(posedge clock); #1;
    cmps++;
    if (tx_valid !== 1'b0) begin errs++; $display("FAIL tx_pulse got tx_valid=%b want 0", tx_valid); end
    do_b(id, resp);
    cmps++;
    if (id !== 5'd7 || resp !== 2'b00) begin
      errs++; $display("FAIL tx_single_b got id=%0d resp=%b want 7 00", id, resp);
    end
  endtask

  task automatic test_tx_backpressure();
    logic [4:0] id; logic [1:0] resp;
    tx_ready = 0;
    do_aw(5'd9, BASE, 8'd1, 2'b00);
    do_w(64'h41, 8'h01, 1'b0);
    wdata = 64'h42; wstrb = 8'h01; wlast = 1; wvalid = 1;
    #1;
    cmps++;
    if (wready !== 1'b0) begin errs++; $display("FAIL tx_stall got wready=%b want 0", wready); end
    @(posedge clock); #1;
    cmps++;
    if (wready !== 1'b0 || tx_data !== 8'h41 || tx_valid !== 1'b1) begin
      errs++; $display("FAIL tx_hold got wready=%b d=%h v=%b want 0 41 1", wready, tx_data, tx_valid);
    end
    tx_ready = 1;
    #1;
    cmps++;
    if (wready !== 1'b1) begin errs++; $display("FAIL tx_release got wready=%b want 1", wready); end
    @(posedge clock); #1;
    wvalid = 0;
    cmps++;
    if (tx_data !== 8'h42 || tx_valid !== 1'b1 || bvalid !== 1'b1) begin
      errs++; $display("FAIL tx_second got d=%h v=%b bvalid=%b want 42 1 1", tx_data, tx_valid, bvalid);
    end
    @(posedge clock); #1;
    cmps++;
    if (tx_valid !== 1'b0) begin errs++; $display("FAIL tx_drain got tx_valid=%b want 0", tx_valid); end
    do_b(id, resp);
    cmps++;
    if (id !== 5'd9 || resp !== 2'b00) begin
      errs++; $display("FAIL tx_bp_b got id=%0d resp=%b want 9 00", id, resp);
    end
  endtask

  task automatic test_scratch_incr();
    logic [4:0] id; logic [1:0] resp; logic [63:0] d; logic l;
    do_aw(5'd4, BASE + 64'h18, 8'd3, 2'b01);
    do_w(64'h1111_2222_3333_4444, 8'h0F, 1'b0);
    do_w(64'hAAAA_BBBB_CCCC_DDDD, 8'hF0, 1'b0);
    do_w(64'hAAAA_BBBB_CCCC_DDDD, 8'hF0, 1'b0);
    do_w(64'hAAAA_BBBB_CCCC_DDDD, 8'hF0, 1'b1);
    do_b(id, resp);
    cmps++;
    if (id !== 5'd4 || resp !== 2'b11) begin
      errs++; $display("FAIL scratch_burst_b got id=%0d resp=%b want 4 11", id, resp);
    end
    do_aw(5'd6, BASE + 64'h18, 8'd0, 2'b01);
    do_w(64'h5555_6666_7777_8888, 8'hF0, 1'b1);
    do_b(id, resp);
    cmps++;
    if (resp !== 2'b00) begin errs++; $display("FAIL scratch_hi_b got resp=%b want 00", resp); end
    do_ar(5'd8, BASE + 64'h18, 8'd0, 2'b01);
    do_r(id, d, resp, l);
    cmps++;
    if (id !== 5'd8 || d !== 64'h5555_6666_3333_4444 || resp !== 2'b00 || l !== 1'b1) begin
      errs++; $display("FAIL scratch_read got id=%0d d=%h resp=%b last=%b want 8 5555666633334444 00 1",
                       id, d, resp, l);
    end
  endtask

  task automatic test_rx();
    logic [4:0] id; logic [1:0] resp; logic [63:0] d; logic l;
    rx_data = 8'h5A; rx_valid = 1;
    #1;
    cmps++;
    if (rx_ready !== 1'b1) begin errs++; $display("FAIL rx_accept got rx_ready=%b want 1", rx_ready); end
    @(posedge clock); #1;
    rx_valid = 0;
    cmps++;
    if (rx_ready !== 1'b0) begin errs++; $display("FAIL rx_full got rx_ready=%b want 0", rx_ready); end
    do_ar(5'd1, BASE + 64'h10, 8'd0, 2'b01);
    do_r(id, d, resp, l);
    cmps++;
    if (d !== 64'h2 || resp !== 2'b00) begin
      errs++; $display("FAIL status_read got d=%h resp=%b want 2 00", d, resp);
    end
    do_ar(5'd2, BASE + 64'h08, 8'd0, 2'b01);
    do_r(id, d, resp, l);
    cmps++;
    if (d !== 64'h15A || id !== 5'd2) begin
      errs++; $display("FAIL rx_read1 got d=%h id=%0d want 15a 2", d, id);
    end
    cmps++;
    if (rx_ready !== 1'b1) begin errs++; $display("FAIL rx_reready got rx_ready=%b want 1", rx_ready); end
    do_ar(5'd2, BASE + 64'h08, 8'd0, 2'b01);
    do_r(id, d, resp, l);
    cmps++;
    if (d !== 64'h05A) begin errs++; $display("FAIL rx_read2 got d=%h want 5a", d); end
  endtask

  task automatic test_concurrent();
    logic [4:0] id; logic [1:0] resp; logic [63:0] d; logic l;
    awid = 5'd11; awaddr = BASE + 64'h08; awlen = 8'd2; awburst = 2'b01; awvalid = 1;
    arid = 5'd12; araddr = BASE + 64'h18; arlen = 8'd0; arburst = 2'b01; arvalid = 1;
    #1;
    cmps++;
    if (awready !== 1'b1 || arready !== 1'b1) begin
      errs++; $display("FAIL dual_ready got aw=%b ar=%b want 1 1", awready, arready);
    end
    @(posedge clock); #1;
    awvalid = 0; arvalid = 0;
    cmps++;
    if (rvalid !== 1'b1) begin errs++; $display("FAIL read_latency got rvalid=%b want 1", rvalid); end
    do_w(64'h1, 8'hFF, 1'b0);
    do_w(64'h2, 8'hFF, 1'b1);
    do_b(id, resp);
    cmps++;
    if (id !== 5'd11 || resp !== 2'b10) begin
      errs++; $display("FAIL early_wlast got id=%0d resp=%b want 11 10", id, resp);
    end
    do_r(id, d, resp, l);
    cmps++;
    if (id !== 5'd12 || d !== 64'h5555_6666_3333_4444 || resp !== 2'b00 || l !== 1'b1) begin
      errs++; $display("FAIL dual_read got id=%0d d=%h resp=%b last=%b want 12 5555666633334444 00 1",
                       id, d, resp, l);
    end
  endtask

  task automatic test_errors();
    logic [4:0] id; logic [1:0] resp; logic [63:0] d; logic l;
    do_ar(5'd3, BASE + 64'h20, 8'd0, 2'b01);
    do_r(id, d, resp, l);
    cmps++;
    if (d !== 64'h0 || resp !== 2'b11) begin
      errs++; $display("FAIL read_above got d=%h resp=%b want 0 11", d, resp);
    end
    do_ar(5'd3, BASE - 64'h8, 8'd0, 2'b01);
    do_r(id, d, resp, l);
    cmps++;
    if (resp !== 2'b11) begin errs++; $display("FAIL read_below got resp=%b want 11", resp); end
    do_ar(5'd3, BASE + 64'h18, 8'd0, 2'b10);
    do_r(id, d, resp, l);
    cmps++;
    if (resp !== 2'b10) begin errs++; $display("FAIL read_wrap got resp=%b want 10", resp); end
    do_aw(5'd13, BASE + 64'h40, 8'd0, 2'b01);
    do_w(64'hFFFF, 8'hFF, 1'b1);
    do_b(id, resp);
    cmps++;
    if (id !== 5'd13 || resp !== 2'b11) begin
      errs++; $display("FAIL write_decerr got id=%0d resp=%b want 13 11", id, resp);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_burst();
    test_tx_single();
    test_tx_backpressure();
    test_scratch_incr();
    test_rx();
    test_concurrent();
    test_errors();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
